// File: rtl/mc_pc_controller_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: opcodes, funct codes,
// state encodings, mux select codes and the ALU operation codes.
package mc_pc_controller_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_RD    = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WR    = 4'd5,
      ST_R_EXEC    = 4'd6,
      ST_R_WB      = 4'd7,
      ST_BRANCH    = 4'd8,
      ST_JUMP      = 4'd9,
      ST_ADDI_EXEC = 4'd10,
      ST_ADDI_WB   = 4'd11,
      ST_JR        = 4'd12
   } state_t;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_RS     = 2'b11;

   localparam logic [1:0] ALUB_B      = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

   // DECODE successor; ST_FETCH doubles as the "unsupported instruction" result.
   function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
      state_t tgt;
      case (op)
         OP_LW, OP_SW: tgt = ST_MEM_ADDR;
         OP_BEQ:       tgt = ST_BRANCH;
         OP_J:         tgt = ST_JUMP;
         OP_ADDI:      tgt = ST_ADDI_EXEC;
         OP_RTYPE: begin
            case (fn)
               FN_JR:                                  tgt = ST_JR;
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  tgt = ST_R_EXEC;
               default:                                tgt = ST_FETCH;
            endcase
         end
         default: tgt = ST_FETCH;
      endcase
      return tgt;
   endfunction

endpackage

// File: rtl/mc_alu_ctrl.sv
// ALU operation decoder: maps the controller's alu_op plus the R-type funct field
// onto the 3-bit ALU operation. Lives next to the ALU, outside the controller.
module mc_alu_ctrl
   import mc_pc_controller_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctl
);

   // Funct is only consulted for R-type execution; unknown functs fall back to add.
   always_comb begin
      alu_ctl = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_ctl = ALU_ADD;
         ALUOP_SUB: alu_ctl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctl = ALU_ADD;
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_SLT:  alu_ctl = ALU_SLT;
               default: alu_ctl = ALU_ADD;
            endcase
         end
         default: alu_ctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_pc_controller.sv
// Multicycle control sequencer: one state register, Moore outputs gated by
// mem_ready/zero, and sole owner of the PC load enable.
module mc_pc_controller
   import mc_pc_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] state,
   output logic       pc_load,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       illegal
);

   state_t cur_state;
   state_t next_state;
   state_t decode_next;

   assign decode_next = decode_target(opcode, funct);
   assign state       = cur_state;

   // State register; async reset lands directly in FETCH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= ST_FETCH;
      end else begin
         cur_state <= next_state;
      end
   end

   // Next-state logic; unreachable codes recover to FETCH.
   always_comb begin
      next_state = ST_FETCH;
      case (cur_state)
         ST_FETCH:     next_state = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE:    next_state = decode_next;
         ST_MEM_ADDR: begin
            if (opcode == OP_LW) begin
               next_state = ST_MEM_RD;
            end else if (opcode == OP_SW) begin
               next_state = ST_MEM_WR;
            end else begin
               next_state = ST_FETCH;
            end
         end
         ST_MEM_RD:    next_state = mem_ready ? ST_MEM_WB : ST_MEM_RD;
         ST_MEM_WB:    next_state = ST_FETCH;
         ST_MEM_WR:    next_state = mem_ready ? ST_FETCH : ST_MEM_WR;
         ST_R_EXEC:    next_state = ST_R_WB;
         ST_R_WB:      next_state = ST_FETCH;
         ST_BRANCH:    next_state = ST_FETCH;
         ST_JUMP:      next_state = ST_FETCH;
         ST_ADDI_EXEC: next_state = ST_ADDI_WB;
         ST_ADDI_WB:   next_state = ST_FETCH;
         ST_JR:        next_state = ST_FETCH;
         default:      next_state = ST_FETCH;
      endcase
   end

   // Output decode; rst forces everything low so no enable leaks through the reset cycle.
   always_comb begin
      pc_load    = 1'b0;
      pc_src     = PC_SRC_ALU;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = ALUB_B;
      alu_op     = ALUOP_ADD;
      illegal    = 1'b0;
      if (rst) begin
         pc_load   = 1'b0;
         mem_write = 1'b0;
      end else begin
         case (cur_state)
            ST_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = ALUB_FOUR;
               ir_write  = mem_ready;
               pc_load   = mem_ready;
            end
            ST_DECODE: begin
               alu_src_b = ALUB_IMM_SH;
               illegal   = (decode_next == ST_FETCH);
            end
            ST_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = ALUB_IMM;
            end
            ST_MEM_RD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
            end
            ST_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
            end
            ST_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = ALUOP_SUB;
               pc_src    = PC_SRC_ALUOUT;
               pc_load   = zero;
            end
            ST_JUMP: begin
               pc_src  = PC_SRC_JUMP;
               pc_load = 1'b1;
            end
            ST_ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = ALUB_IMM;
            end
            ST_ADDI_WB: begin
               reg_write = 1'b1;
            end
            ST_JR: begin
               pc_src  = PC_SRC_RS;
               pc_load = 1'b1;
            end
            default: begin
               pc_load = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_pc_controller.sv
// Self-checking bench for mc_pc_controller: directed scenarios then random instruction
// streams, compared cycle by cycle against a behavioural instruction-level model.
module tb_mc_pc_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic [3:0] state;
   logic       pc_load, iord, mem_read, mem_write, ir_write, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, illegal;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [2:0] alu_ctl;

   int tests = 0;
   int fails = 0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
   localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, RT = 6'b000000;
   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
   localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_JR = 6'b001000;

   mc_pc_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .state(state), .pc_load(pc_load), .pc_src(pc_src),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal)
   );

   mc_alu_ctrl u_alu_ctrl (.alu_op(alu_op), .funct(funct), .alu_ctl(alu_ctl));

   always #5 clk = ~clk;

   wire [15:0] obs_vec = {pc_load, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                          reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};

   function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
      if (op == LW || op == SW || op == BEQ || op == JMP || op == ADDI) return 1'b1;
      if (op == RT)
         return (fn == F_ADD || fn == F_SUB || fn == F_AND || fn == F_OR ||
                 fn == F_SLT || fn == F_JR);
      return 1'b0;
   endfunction

   // Expected control word for a state number, straight from the per-state table.
   function automatic logic [15:0] exp_out(int st, bit rdy, bit z, bit bad);
      logic pl, ird, mr, mw, irw, rw, rd, m2r, asa, ill;
      logic [1:0] ps, asb, aop;
      {pl, ird, mr, mw, irw, rw, rd, m2r, asa, ill} = 10'b0;
      ps = 2'b00; asb = 2'b00; aop = 2'b00;
      case (st)
         0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pl = rdy; end
         1:  begin asb = 2'b11; ill = bad; end
         2:  begin asa = 1'b1; asb = 2'b10; end
         3:  begin ird = 1'b1; mr = 1'b1; end
         4:  begin rw = 1'b1; m2r = 1'b1; end
         5:  begin ird = 1'b1; mw = 1'b1; end
         6:  begin asa = 1'b1; aop = 2'b10; end
         7:  begin rw = 1'b1; rd = 1'b1; end
         8:  begin asa = 1'b1; aop = 2'b01; ps = 2'b01; pl = z; end
         9:  begin ps = 2'b10; pl = 1'b1; end
         10: begin asa = 1'b1; asb = 2'b10; end
         11: begin rw = 1'b1; end
         12: begin ps = 2'b11; pl = 1'b1; end
         default: begin pl = 1'b0; end
      endcase
      return {pl, ps, ird, mr, mw, irw, rw, rd, m2r, asa, asb, aop, ill};
   endfunction

   function automatic logic [2:0] exp_alu(logic [1:0] aop, logic [5:0] fn);
      if (aop == 2'b01) return 3'b110;
      if (aop != 2'b10) return 3'b010;
      case (fn)
         F_SUB:   return 3'b110;
         F_AND:   return 3'b000;
         F_OR:    return 3'b001;
         F_SLT:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs just after the edge, check, advance to just after the next edge.
   task automatic step(int st, bit rdy, bit z, bit bad, string tag);
      logic [15:0] e;
      mem_ready = rdy;
      zero      = z;
      #1;
      e = exp_out(st, rdy, z, bad);
      chk({tag, " state"}, {28'd0, state}, st);
      chk({tag, " outputs"}, {16'd0, obs_vec}, {16'd0, e});
      chk({tag, " alu_ctl"}, {29'd0, alu_ctl}, {29'd0, exp_alu(e[2:1], funct)});
      @(posedge clk);
      #1;
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected state walk of one instruction derived from its class and wait counts.
   task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit bz, int wf, int wm, string tag);
      bit bad;
      int ws;
      bad    = !is_legal(op, fn);
      opcode = op;
      funct  = fn;
      for (int i = 0; i < wf; i++) step(0, 1'b0, rb(), bad, tag);
      step(0, 1'b1, rb(), bad, tag);
      step(1, rb(), rb(), bad, tag);
      if (!bad) begin
         if (op == LW || op == SW) begin
            step(2, rb(), rb(), bad, tag);
            ws = (op == LW) ? 3 : 5;
            for (int i = 0; i < wm; i++) step(ws, 1'b0, rb(), bad, tag);
            step(ws, 1'b1, rb(), bad, tag);
            if (op == LW) step(4, rb(), rb(), bad, tag);
         end else if (op == RT && fn == F_JR) begin
            step(12, rb(), rb(), bad, tag);
         end else if (op == RT) begin
            step(6, rb(), rb(), bad, tag);
            step(7, rb(), rb(), bad, tag);
         end else if (op == BEQ) begin
            step(8, rb(), bz, bad, tag);
         end else if (op == JMP) begin
            step(9, rb(), rb(), bad, tag);
         end else begin
            step(10, rb(), rb(), bad, tag);
            step(11, rb(), rb(), bad, tag);
         end
      end
   endtask

   initial begin
      logic [5:0] legal_fn [5];
      logic [5:0] op;
      logic [5:0] fn;
      int k;
      legal_fn[0] = F_ADD; legal_fn[1] = F_SUB; legal_fn[2] = F_AND;
      legal_fn[3] = F_OR;  legal_fn[4] = F_SLT;

      // Reset holds FETCH with every output low, even with mem_ready high.
      rst = 1'b1; opcode = LW; funct = 6'd0; zero = 1'b1; mem_ready = 1'b1;
      #2;
      chk("reset state", {28'd0, state}, 32'd0);
      chk("reset outputs", {16'd0, obs_vec}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      chk("reset held outputs", {16'd0, obs_vec}, 32'd0);
      rst = 1'b0;

      run_instr(LW, 6'd0, 1'b0, 0, 0, "lw nowait");
      run_instr(RT, F_ADD, 1'b0, 3, 0, "fetch wait3 add");
      run_instr(BEQ, 6'd0, 1'b1, 0, 0, "beq taken");
      run_instr(BEQ, 6'd0, 1'b0, 0, 0, "beq not taken");
      run_instr(JMP, 6'd0, 1'b0, 0, 0, "j");
      run_instr(RT, F_JR, 1'b0, 0, 0, "jr");
      run_instr(6'b111111, 6'd0, 1'b0, 0, 0, "illegal op");
      run_instr(RT, 6'b000111, 1'b0, 0, 0, "illegal funct");
      run_instr(SW, 6'd0, 1'b0, 1, 2, "sw waits");
      run_instr(ADDI, 6'd0, 1'b0, 0, 0, "addi");
      run_instr(RT, F_SLT, 1'b0, 0, 0, "slt");

      // Reset during MEM_WR aborts the store within the same cycle.
      opcode = SW; funct = 6'd0;
      step(0, 1'b1, 1'b0, 1'b0, "rst-midwr");
      step(1, 1'b0, 1'b0, 1'b0, "rst-midwr");
      step(2, 1'b0, 1'b0, 1'b0, "rst-midwr");
      mem_ready = 1'b0;
      #1;
      chk("pre-rst memwr state", {28'd0, state}, 32'd5);
      rst = 1'b1;
      #1;
      chk("rst in memwr state", {28'd0, state}, 32'd0);
      chk("rst in memwr mem_write", {31'd0, mem_write}, 32'd0);
      chk("rst in memwr outputs", {16'd0, obs_vec}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(LW, 6'd0, 1'b0, 0, 1, "post-rst lw");

      // Random instruction stream, including random illegal encodings.
      for (int n = 0; n < 300; n++) begin
         k  = $urandom_range(0, 9);
         fn = 6'($urandom);
         case (k)
            0: op = LW;
            1: op = SW;
            2: op = BEQ;
            3: op = JMP;
            4: op = ADDI;
            5, 6: begin op = RT; fn = legal_fn[$urandom_range(0, 4)]; end
            7: begin op = RT; fn = F_JR; end
            8: op = 6'($urandom);
            default: op = RT;
         endcase
         run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2), "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
